// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: assembles UART receiver bytes into SYNC/LEN/payload/CSUM
// frames, checks the XOR checksum and streams the payload out over valid/ready.
module uart_rx_frame_ctrl #(
    parameter int unsigned MAX_LEN       = 16,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned TIMEOUT_TICKS = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       s_tick,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_ok,
    output logic       csum_err,
    output logic       len_err,
    output logic       timeout_err,
    output logic       overrun_err,
    output logic [7:0] frame_count
);

    localparam int unsigned PW = $clog2(MAX_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [2:0] {StHunt, StLen, StPayload, StCsum, StDrain} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   len_q, len_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   rd_nxt;
    logic [7:0]      csum_q, csum_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [7:0]      frame_count_q, frame_count_d;
    logic            frame_ok_q, frame_ok_d;
    logic            csum_err_q, csum_err_d;
    logic            len_err_q, len_err_d;
    logic            timeout_err_q, timeout_err_d;
    logic            overrun_err_q, overrun_err_d;
    logic            buf_we;

    // Sized to the full pointer range so every pointer value indexes legally.
    logic [7:0] buf_mem [2**PW];

    // Next-state, datapath and pulse generation.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        csum_d        = csum_q;
        tcnt_d        = tcnt_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        frame_count_d = frame_count_q;
        frame_ok_d    = 1'b0;
        csum_err_d    = 1'b0;
        len_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        overrun_err_d = 1'b0;
        buf_we        = 1'b0;
        rd_nxt        = rd_ptr_q + PW'(1);

        // Inter-byte timeout for an open frame; a byte in the same cycle wins.
        if (state_q inside {StLen, StPayload, StCsum}) begin
            if (rx_done) begin
                tcnt_d = '0;
            end else if (s_tick) begin
                if (tcnt_q == TW'(TIMEOUT_TICKS - 1)) begin
                    tcnt_d        = '0;
                    timeout_err_d = 1'b1;
                    state_d       = StHunt;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
        end else begin
            tcnt_d = '0;
        end

        unique case (state_q)
            StHunt: begin
                if (rx_done && rx_data == SYNC_BYTE) begin
                    csum_d  = '0;
                    state_d = StLen;
                end
            end
            StLen: begin
                if (rx_done) begin
                    if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                        len_err_d = 1'b1;
                        state_d   = StHunt;
                    end else begin
                        len_d    = rx_data[PW-1:0];
                        csum_d   = rx_data;
                        wr_ptr_d = '0;
                        state_d  = StPayload;
                    end
                end
            end
            StPayload: begin
                if (rx_done) begin
                    buf_we   = 1'b1;
                    csum_d   = csum_q ^ rx_data;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (wr_ptr_q == len_q - PW'(1)) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (rx_done) begin
                    if (rx_data == csum_q) begin
                        frame_ok_d    = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                        rd_ptr_d      = '0;
                        out_data_d    = buf_mem[0];
                        out_last_d    = (len_q == PW'(1));
                        state_d       = StDrain;
                    end else begin
                        csum_err_d = 1'b1;
                        state_d    = StHunt;
                    end
                end
            end
            StDrain: begin
                // The receiver cannot be stalled, so bytes arriving now are lost.
                if (rx_done) begin
                    overrun_err_d = 1'b1;
                end
                if (out_ready) begin
                    if (out_last_q) begin
                        out_data_d = '0;
                        out_last_d = 1'b0;
                        state_d    = StHunt;
                    end else begin
                        rd_ptr_d   = rd_nxt;
                        out_data_d = buf_mem[rd_nxt];
                        out_last_d = (rd_nxt == len_q - PW'(1));
                    end
                end
            end
            default: state_d = StHunt;
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StHunt;
            len_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            csum_q        <= '0;
            tcnt_q        <= '0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            frame_count_q <= '0;
            frame_ok_q    <= 1'b0;
            csum_err_q    <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            csum_q        <= csum_d;
            tcnt_q        <= tcnt_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            frame_count_q <= frame_count_d;
            frame_ok_q    <= frame_ok_d;
            csum_err_q    <= csum_err_d;
            len_err_q     <= len_err_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    // Payload buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wr_ptr_q] <= rx_data;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = (state_q == StDrain);
    assign out_last    = out_last_q;
    assign busy        = (state_q != StHunt);
    assign frame_ok    = frame_ok_q;
    assign csum_err    = csum_err_q;
    assign len_err     = len_err_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: expected payload bytes are queued
// as frames are driven and compared as the DUT transfers them.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       s_tick = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       frame_ok;
    logic       csum_err;
    logic       len_err;
    logic       timeout_err;
    logic       overrun_err;
    logic [7:0] frame_count;

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard entries are {last, data}.
    logic [8:0] exp_q [$];

    // Pulse counts seen on the outputs versus the model's expectations.
    int n_ok = 0, n_cerr = 0, n_lerr = 0, n_to = 0, n_ovr = 0;
    int e_ok = 0, e_cerr = 0, e_lerr = 0, e_to = 0, e_ovr = 0;
    logic [7:0] exp_count = '0;

    logic       prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [7:0] prev_d = '0;

    uart_rx_frame_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .s_tick      (s_tick),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .frame_ok    (frame_ok),
        .csum_err    (csum_err),
        .len_err     (len_err),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pulse counting, scoreboard pops and stall stability.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_ok)    n_ok++;
            if (csum_err)    n_cerr++;
            if (len_err)     n_lerr++;
            if (timeout_err) n_to++;
            if (overrun_err) n_ovr++;
            if (prev_v && !prev_r) begin
                check("hold", {29'd0, out_valid, out_last, out_data[0]},
                      {29'd0, 1'b1, prev_l, prev_d[0]});
                check("hold_data", {24'd0, out_data}, {24'd0, prev_d});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    check("out", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
                end
            end
        end
        prev_v = out_valid;
        prev_r = out_ready;
        prev_l = out_last;
        prev_d = out_data;
    end

    // Drive one byte for one cycle; entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    // Drive a complete frame, queueing its payload when the checksum is correct.
    task automatic send_frame(input logic [7:0] pl[$], input logic good);
        logic [7:0] cs;
        cs = 8'(pl.size());
        foreach (pl[i]) cs ^= pl[i];
        if (good) begin
            foreach (pl[i]) exp_q.push_back({(i == pl.size() - 1), pl[i]});
            e_ok++;
            exp_count++;
        end else begin
            e_cerr++;
        end
        send_byte(8'hA5);
        send_byte(8'(pl.size()));
        foreach (pl[i]) send_byte(pl[i]);
        send_byte(good ? cs : ~cs);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(tag, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_ok"},   n_ok,   e_ok);
        check({tag, "_cerr"}, n_cerr, e_cerr);
        check({tag, "_lerr"}, n_lerr, e_lerr);
        check({tag, "_to"},   n_to,   e_to);
        check({tag, "_ovr"},  n_ovr,  e_ovr);
        check({tag, "_cnt"},  {24'd0, frame_count}, {24'd0, exp_count});
        check({tag, "_sb"},   exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] pl[$];

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {9'd0, out_data, out_valid, out_last, busy, frame_ok, csum_err,
                             len_err, timeout_err, overrun_err, frame_count}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Good frame with latency and back-to-back throughput.
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(pl, 1'b1);
        @(negedge clk);
        check("first_valid", {31'd0, out_valid}, 32'd1);
        check("frame_ok_pulse", {31'd0, frame_ok}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("streaming", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        check("idle_after_drain", {30'd0, out_valid, busy}, 32'd0);
        @(posedge clk); #1;
        check_counts("good");

        // Bad checksum then a good 1-byte frame.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
        send_byte(8'h00);
        e_cerr++;
        wait_idle("cerr_idle");
        pl = '{8'h5A};
        send_frame(pl, 1'b1);
        wait_idle("after_cerr_idle");
        check_counts("cerr");

        // Length errors, then a frame whose payload contains the sync value.
        send_byte(8'hA5); send_byte(8'h00);
        e_lerr++;
        send_byte(8'hA5); send_byte(8'h11);
        e_lerr++;
        wait_idle("lerr_idle");
        pl = '{8'h7E, 8'hA5};
        send_frame(pl, 1'b1);
        wait_idle("after_lerr_idle");
        check_counts("lerr");

        // Timeout exactly on the 480th tick.
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        s_tick = 1'b1;
        repeat (479) begin @(posedge clk); #1; end
        @(negedge clk);
        check("no_to_479", {30'd0, timeout_err, busy}, 32'd1);
        @(posedge clk); #1;
        s_tick = 1'b0;
        @(negedge clk);
        check("to_480", {30'd0, timeout_err, busy}, 32'd2);
        e_to++;
        @(posedge clk); #1;

        // Byte on the 480th tick clears the counter; frame completes.
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        s_tick = 1'b1;
        repeat (479) begin @(posedge clk); #1; end
        send_byte(8'h02);
        repeat (478) begin @(posedge clk); #1; end
        s_tick = 1'b0;
        send_byte(8'h03); send_byte(8'h04);
        exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b0, 8'h03}); exp_q.push_back({1'b1, 8'h04});
        e_ok++; exp_count++;
        send_byte(8'h04 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
        wait_idle("to_race_idle");
        check_counts("timeout");

        // Backpressure with an overrun byte during the stall.
        out_ready = 1'b0;
        pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        send_frame(pl, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        send_byte(8'h55);
        e_ovr++;
        repeat (6) begin @(posedge clk); #1; end
        check("stalled_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_idle("bp_idle");
        check_counts("bp");

        // Reset mid-payload discards silently.
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_outs", {9'd0, out_data, out_valid, out_last, busy, frame_ok, csum_err,
                                len_err, timeout_err, overrun_err, frame_count}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_count = '0;
        @(posedge clk); #1;
        check_counts("midreset");

        // 256 good frames wrap frame_count back to zero.
        for (int i = 0; i < 256; i++) begin
            pl = '{8'(i)};
            send_frame(pl, 1'b1);
            wait_idle("wrap_idle");
        end
        check("wrap_zero", {24'd0, frame_count}, 32'd0);
        check_counts("wrap");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
